video_out_streamer: RTL and testbench
=====================================

Name: video_out_streamer

Overview:
- Transmit-side counterpart of the HDMI input loader.
- Generates free-running raster timing (hsync/vsync/de) for the HDMI/ADV transmitter path.
- Pulls pixels from the output FIFO (1-cycle read latency) and drives time-aligned RGB.
- Blanks whole frames when the FIFO is not sufficiently pre-filled at frame start, so sync never stalls.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 1'b0, sync active level (0 = active-low)
- PREFILL, 640, minimum fifo_rd_count_i at frame start to arm the frame

Ports:
- sys_clk_96M  in  1  pixel/system clock; all logic in this domain
- sys_rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  level; transmitter configured, timing may run
- fifo_rdata_i  in  24  FIFO read data, valid the cycle after fifo_rd_en_o
- fifo_empty_i  in  1  FIFO empty
- fifo_rd_count_i  in  16  FIFO read-side fill level
- clr_underflow_i  in  1  pulse; clears underflow_o
- fifo_rd_en_o  out  1  FIFO read strobe
- rgb_o  out  24  pixel data; 0 whenever de_o=0
- de_o  out  1  data enable
- hsync_o  out  1  horizontal sync, polarity SYNC_POL
- vsync_o  out  1  vertical sync, polarity SYNC_POL
- frame_start_o  out  1  one-cycle pulse aligned with first output cycle of each frame
- underflow_o  out  1  sticky: read needed while FIFO empty
- state_o  out  2  current FSM state, for debug

Behaviour:
- Reset values: fifo_rd_en_o=0, rgb_o=0, de_o=0, hsync_o=vsync_o=~SYNC_POL, frame_start_o=0, underflow_o=0, state=IDLE, h_cnt=v_cnt=0.
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters (11 bits each):
  - h_cnt 0..H_TOTAL-1, wraps to 0.
  - v_cnt increments when h_cnt wraps; wraps at V_TOTAL-1.
- Region order per line/frame: active, front porch, sync, back porch.
  - hsync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync active on the equivalent line range of v_cnt.
  - active_pre = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
- FSM states: IDLE=0, RUN_BLANK=1, RUN_ACTIVE=2.
  - IDLE: counters held at 0, all outputs at reset values. start_i=1 → go to RUN_ACTIVE if fifo_rd_count_i>=PREFILL, else RUN_BLANK.
  - Frame boundary (h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1), from RUN_BLANK or RUN_ACTIVE: next state is RUN_ACTIVE if fifo_rd_count_i>=PREFILL, else RUN_BLANK. The decision is taken only at the frame boundary; no mid-frame change.
  - start_i=0 in any state → IDLE on the next cycle, counters cleared, outputs to reset values.
- Read and underflow:
  - fifo_rd_en_o = RUN_ACTIVE && active_pre && !fifo_empty_i (combinational from registered state/counters).
  - RUN_ACTIVE && active_pre && fifo_empty_i → underflow_o set; that pixel outputs rgb 0 with de_o still 1. Timing never stalls.
- Output stage, exactly 1-cycle latency from counters:
  - de_o <= active_pre (in both RUN states).
  - hsync_o/vsync_o <= decoded sync.
  - rgb_o = fifo_rdata_i if the previous cycle issued a read, else 0.
  - RUN_BLANK: de_o still follows active_pre; rgb_o=0; no reads.
- frame_start_o: registered; high in the cycle de_o first rises for the frame (counter position h=0,v=0 delayed by 1).
- underflow_o: sticky. Set takes priority over clr_underflow_i in the same cycle. Cleared by reset.
- Reset mid-frame: immediate asynchronous return to reset values; FIFO contents untouched.

Decomposition:
- Package video_out_pkg:
  - state encoding (IDLE/RUN_BLANK/RUN_ACTIVE)
  - default 640x480@60 timing constants
  - H_TOTAL/V_TOTAL derivation
- Sub-module video_timing_counter:
  - h/v counters, wrap logic, region decode
  - outputs active_pre, hs_pre, vs_pre, frame_end
- Top video_out_streamer: FSM, FIFO handshake, output register stage, underflow flag.

Test Plan:
- Reset, start_i=1, fifo_rd_count_i=1000, FIFO model of incrementing data → de_o first high 1 cycle after start; rgb_o=0,1,2…639 on line 0; 640 de cycles/line; 480 active lines; 525×800 cycles between frame_start_o pulses.
- Sync check, defaults → hsync_o low for cycles 656..751 (1-cycle delayed) of every line; vsync_o low on lines 490..491; no de_o during either.
- fifo_rd_count_i=100 at frame boundary → state_o=1 for the whole next frame; zero fifo_rd_en_o pulses; de_o toggles normally with rgb_o=0; count raised to 700 → RUN_ACTIVE from the following frame.
- fifo_empty_i forced high for 5 pixels mid-line in RUN_ACTIVE → 5 missing rd_en pulses; rgb_o=0 at those positions; underflow_o=1 until clr_underflow_i; simultaneous set+clr leaves it 1.
- start_i dropped at pixel 300 of line 10 → next cycle state_o=0, all outputs at reset values; re-assert → frame restarts at h=0,v=0 with frame_start_o.
- sys_rst_n pulsed low mid-active → outputs immediately at reset values, async; normal restart after release.

Source files
------------

// File: rtl/video_out_pkg.sv
// Shared state encoding and default 640x480@60 raster timing for the video output path.
package video_out_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN_BLANK  = 2'd1,
    RUN_ACTIVE = 2'd2
  } state_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_PREFILL  = 640;

  function automatic int line_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/video_out_streamer_timing.sv
// Free-running h/v raster counters with region decode; counters sit at 0 whenever run is low.
module video_timing_counter
  import video_out_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic sys_clk_96M,
  input  logic sys_rst_n,
  input  logic run,
  output logic active_pre,
  output logic hs_pre,
  output logic vs_pre,
  output logic frame_end,
  output logic frame_first
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;

  always_ff @(posedge sys_clk_96M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign active_pre  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_pre      = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_pre      = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign frame_end   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign frame_first = (h_cnt == 11'd0) && (v_cnt == 11'd0);

endmodule

// File: rtl/video_out_streamer.sv
// Transmit-side raster generator: pulls pixels from the output FIFO and blanks whole
// frames that were not pre-filled at frame start, so sync timing never stalls.
module video_out_streamer
  import video_out_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PREFILL  = DEF_PREFILL
) (
  input  logic        sys_clk_96M,
  input  logic        sys_rst_n,
  input  logic        start_i,
  input  logic [23:0] fifo_rdata_i,
  input  logic        fifo_empty_i,
  input  logic [15:0] fifo_rd_count_i,
  input  logic        clr_underflow_i,
  output logic        fifo_rd_en_o,
  output logic [23:0] rgb_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        frame_start_o,
  output logic        underflow_o,
  output logic [1:0]  state_o
);

  state_t state;
  state_t state_nxt;
  logic   run;
  logic   armed;
  logic   active_pre;
  logic   hs_pre;
  logic   vs_pre;
  logic   frame_end;
  logic   frame_first;
  logic   starve;
  logic   rd_q;

  assign run   = start_i && (state != IDLE);
  assign armed = fifo_rd_count_i >= 16'(PREFILL);

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .sys_clk_96M (sys_clk_96M),
    .sys_rst_n   (sys_rst_n),
    .run         (run),
    .active_pre  (active_pre),
    .hs_pre      (hs_pre),
    .vs_pre      (vs_pre),
    .frame_end   (frame_end),
    .frame_first (frame_first)
  );

  always_ff @(posedge sys_clk_96M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The arm/blank choice is only revisited on the last pixel of a frame.
  always_comb begin
    state_nxt = state;
    if (!start_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:                  state_nxt = armed ? RUN_ACTIVE : RUN_BLANK;
        RUN_BLANK, RUN_ACTIVE: if (frame_end) state_nxt = armed ? RUN_ACTIVE : RUN_BLANK;
        default:               state_nxt = IDLE;
      endcase
    end
  end

  assign fifo_rd_en_o = (state == RUN_ACTIVE) && active_pre && !fifo_empty_i;
  assign starve       = (state == RUN_ACTIVE) && active_pre && fifo_empty_i;

  always_ff @(posedge sys_clk_96M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_q          <= 1'b0;
      de_o          <= 1'b0;
      hsync_o       <= ~SYNC_POL;
      vsync_o       <= ~SYNC_POL;
      frame_start_o <= 1'b0;
      underflow_o   <= 1'b0;
    end else if (!run) begin
      rd_q          <= 1'b0;
      de_o          <= 1'b0;
      hsync_o       <= ~SYNC_POL;
      vsync_o       <= ~SYNC_POL;
      frame_start_o <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      rd_q          <= fifo_rd_en_o;
      de_o          <= active_pre;
      hsync_o       <= hs_pre ? SYNC_POL : ~SYNC_POL;
      vsync_o       <= vs_pre ? SYNC_POL : ~SYNC_POL;
      frame_start_o <= frame_first;
      if (starve) begin
        underflow_o <= 1'b1;
      end else if (clr_underflow_i) begin
        underflow_o <= 1'b0;
      end
    end
  end

  // FIFO data arrives one cycle after the strobe, already aligned with de_o.
  assign rgb_o   = rd_q ? fifo_rdata_i : 24'd0;
  assign state_o = state;

endmodule

// File: tb/tb_video_out_streamer.sv
// Directed bench for video_out_streamer on a shrunken 16x8 raster (8x4 active).
module tb_video_out_streamer;

  localparam int HT = 16;
  localparam int HA = 8;
  localparam int VA = 4;
  localparam int FT = 128;

  logic        sys_clk_96M = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [23:0] fifo_rdata_i = 24'd0;
  logic        fifo_empty_i = 1'b0;
  logic [15:0] fifo_rd_count_i = 16'd0;
  logic        clr_underflow_i = 1'b0;
  logic        fifo_rd_en_o;
  logic [23:0] rgb_o;
  logic        de_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        frame_start_o;
  logic        underflow_o;
  logic [1:0]  state_o;

  int total = 0;
  int bad = 0;
  int exp_pix = 0;
  int frame_state = 2;
  int next_count = 100;
  int sv_lo = -1;
  int sv_hi = -1;
  int clr_a = -1;
  int clr_b = -1;
  int rd_pulses = 0;
  int uf_exp = 0;
  logic [23:0] fifo_next = 24'd0;

  video_out_streamer #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .SYNC_POL (1'b0),
    .PREFILL  (8)
  ) dut (
    .sys_clk_96M     (sys_clk_96M),
    .sys_rst_n       (sys_rst_n),
    .start_i         (start_i),
    .fifo_rdata_i    (fifo_rdata_i),
    .fifo_empty_i    (fifo_empty_i),
    .fifo_rd_count_i (fifo_rd_count_i),
    .clr_underflow_i (clr_underflow_i),
    .fifo_rd_en_o    (fifo_rd_en_o),
    .rgb_o           (rgb_o),
    .de_o            (de_o),
    .hsync_o         (hsync_o),
    .vsync_o         (vsync_o),
    .frame_start_o   (frame_start_o),
    .underflow_o     (underflow_o),
    .state_o         (state_o)
  );

  always #5 sys_clk_96M = ~sys_clk_96M;

  // FIFO model: incrementing pixel values, one-cycle read latency.
  always @(posedge sys_clk_96M) begin
    if (fifo_rd_en_o) begin
      fifo_rdata_i <= fifo_next;
      fifo_next    <= fifo_next + 24'd1;
    end
  end

  task automatic checkOutput(input string tag, input int p, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s p=%0d: got %0h want %0h", tag, p, got, want);
    end
  endtask

  function automatic bit starved(input int q);
    return (q >= sv_lo) && (q < sv_hi);
  endfunction

  task automatic expectPixel(input int p);
    int h = p % HT;
    int v = p / HT;
    bit de = (h < HA) && (v < VA);
    bit hs = !((h >= 10) && (h < 13));
    bit vs = !((v >= 5) && (v < 7));
    bit set_uf = de && (frame_state == 2) && starved(p);
    logic [23:0] rgb = 24'd0;
    if (de && (frame_state == 2) && !starved(p)) begin
      rgb = 24'(exp_pix);
      exp_pix++;
    end
    if (set_uf) uf_exp = 1;
    else if ((p == clr_a) || (p == clr_b)) uf_exp = 0;
    checkOutput("de", p, 32'(de_o), 32'(de));
    checkOutput("hsync", p, 32'(hsync_o), 32'(hs));
    checkOutput("vsync", p, 32'(vsync_o), 32'(vs));
    checkOutput("frame_start", p, 32'(frame_start_o), 32'(p == 0));
    checkOutput("rgb", p, 32'(rgb_o), 32'(rgb));
    checkOutput("underflow", p, 32'(underflow_o), 32'(uf_exp));
    if (p < FT - 1) checkOutput("state", p, 32'(state_o), 32'(frame_state));
  endtask

  task automatic applyStimulus(input int first, input int last);
    for (int p = first; p <= last; p++) begin
      @(negedge sys_clk_96M);
      expectPixel(p);
      fifo_empty_i    = starved(p + 1);
      clr_underflow_i = ((p + 1) == clr_a) || ((p + 1) == clr_b);
      if (p == 64) fifo_rd_count_i = 16'(next_count);
      #1;
      if ((p < FT - 1) && fifo_rd_en_o) rd_pulses++;
    end
  endtask

  task automatic expectIdle(input string tag);
    checkOutput({tag, ".state"}, -1, 32'(state_o), 32'd0);
    checkOutput({tag, ".de"}, -1, 32'(de_o), 32'd0);
    checkOutput({tag, ".rgb"}, -1, 32'(rgb_o), 32'd0);
    checkOutput({tag, ".hsync"}, -1, 32'(hsync_o), 32'd1);
    checkOutput({tag, ".vsync"}, -1, 32'(vsync_o), 32'd1);
    checkOutput({tag, ".rd_en"}, -1, 32'(fifo_rd_en_o), 32'd0);
    checkOutput({tag, ".frame_start"}, -1, 32'(frame_start_o), 32'd0);
    checkOutput({tag, ".underflow"}, -1, 32'(underflow_o), 32'd0);
  endtask

  initial begin
    fifo_rd_count_i = 16'd100;
    #12;
    expectIdle("reset");
    @(negedge sys_clk_96M);
    sys_rst_n = 1'b1;
    @(negedge sys_clk_96M);
    expectIdle("idle");

    // Frame A: armed, full frame of incrementing pixels; count dropped mid-frame.
    start_i = 1'b1;
    @(negedge sys_clk_96M);
    checkOutput("start.state", -1, 32'(state_o), 32'd2);
    checkOutput("start.de", -1, 32'(de_o), 32'd0);
    frame_state = 2; next_count = 3; rd_pulses = 0;
    applyStimulus(0, FT - 1);
    checkOutput("frameA.reads", -1, 32'(rd_pulses), 32'd31);

    // Frame B: not pre-filled, blanked with no reads.
    frame_state = 1; next_count = 100; rd_pulses = 0;
    applyStimulus(0, FT - 1);
    checkOutput("frameB.reads", -1, 32'(rd_pulses), 32'd0);

    // Frame C: five starved pixels on line 1.
    frame_state = 2; sv_lo = 18; sv_hi = 23; rd_pulses = 0;
    applyStimulus(0, FT - 1);
    checkOutput("frameC.reads", -1, 32'(rd_pulses), 32'd26);
    checkOutput("frameC.underflow", -1, 32'(underflow_o), 32'd1);

    // Frame D: clear pulse, then starve with a simultaneous clear.
    sv_lo = 36; sv_hi = 37; clr_a = 6; clr_b = 36;
    applyStimulus(0, FT - 1);
    checkOutput("frameD.underflow", -1, 32'(underflow_o), 32'd1);
    sv_lo = -1; sv_hi = -1; clr_a = -1; clr_b = -1;

    // Frame E: drop start at pixel 3 of line 2; that cycle's read still pops the FIFO.
    applyStimulus(0, 34);
    start_i = 1'b0;
    exp_pix++;
    @(negedge sys_clk_96M);
    expectIdle("stop");
    uf_exp = 0;

    // Frame F: restart, then async reset mid-active.
    start_i = 1'b1;
    @(negedge sys_clk_96M);
    checkOutput("restart.state", -1, 32'(state_o), 32'd2);
    applyStimulus(0, 49);
    #2 sys_rst_n = 1'b0;
    #1 expectIdle("async_rst");
    @(negedge sys_clk_96M);
    sys_rst_n = 1'b1;
    @(negedge sys_clk_96M);
    checkOutput("rst_restart.state", -1, 32'(state_o), 32'd2);
    checkOutput("rst_restart.de", -1, 32'(de_o), 32'd0);

    // Frame G: normal frame after reset release.
    applyStimulus(0, FT - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
